// File: rtl/pulse_width_meter.sv
// RC receiver pulse-width meter: synchronizes the raw PWM input, measures each
// high time in prescaled ticks, filters out-of-range pulses and flags signal loss.
module pulse_width_meter #(
    parameter int TICK_DIV  = 100,
    parameter int MIN_WIDTH = 80,
    parameter int MAX_WIDTH = 220,
    parameter int TIMEOUT   = 5000,
    parameter int FAILSAFE  = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       PWM_In,
    output logic [7:0] PulWid,
    output logic       PulWid_Valid,
    output logic       Sig_Lost
);

    localparam int              PRE_W      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(TICK_DIV - 1);
    localparam logic [15:0]     TIMEOUT_C  = 16'(TIMEOUT);
    localparam logic [7:0]      FAILSAFE_C = 8'(FAILSAFE);
    localparam logic [7:0]      MIN_C      = 8'(MIN_WIDTH);
    localparam logic [7:0]      MAX_C      = 8'(MAX_WIDTH);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t           state, state_next;
    logic             sync_p0, sync_p1, sync_p2;
    logic             rise, fall, tick, accept, in_range;
    logic [PRE_W-1:0] pre_cnt;
    logic [7:0]       width, width_inc;
    logic [15:0]      gap_cnt;

    // Stage p0/p1: two-flop synchronizer; p2 is the edge-detect history.
    // Reset to 1 so an input already high at reset exit is not seen as a rise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
            sync_p2 <= 1'b1;
        end else begin
            sync_p0 <= PWM_In;
            sync_p1 <= sync_p0;
            sync_p2 <= sync_p1;
        end
    end

    assign rise = sync_p1 & ~sync_p2;
    assign fall = ~sync_p1 & sync_p2;
    assign tick = (pre_cnt == PRE_LAST);

    // Prescaler restarts on each rise so the tick grid aligns with the pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pre_cnt <= '0;
        else if (rise || tick)
            pre_cnt <= '0;
        else
            pre_cnt <= pre_cnt + 1'b1;
    end

    // The tick landing on the falling-edge cycle still belongs to the pulse.
    assign width_inc = tick ? sat_inc8(width) : width;
    assign in_range  = (width_inc >= MIN_C) && (width_inc <= MAX_C);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: if (rise) state_next = HIGH;
            HIGH: begin
                if (fall) begin
                    state_next = LOW;
                    accept     = in_range;
                end
            end
            LOW:  if (rise) state_next = HIGH;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            width <= '0;
        else if (rise)
            width <= '0;
        else if (state == HIGH)
            width <= width_inc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            gap_cnt <= '0;
        else if (accept)
            gap_cnt <= '0;
        else if (tick)
            gap_cnt <= sat_inc16(gap_cnt);
    end

    // Acceptance takes priority over a coincident timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            PulWid       <= FAILSAFE_C;
            PulWid_Valid <= 1'b0;
            Sig_Lost     <= 1'b1;
        end else begin
            PulWid_Valid <= accept;
            if (accept) begin
                PulWid   <= width_inc;
                Sig_Lost <= 1'b0;
            end else if (gap_cnt >= TIMEOUT_C) begin
                PulWid   <= FAILSAFE_C;
                Sig_Lost <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pulse_width_meter.sv
// Directed bench for pulse_width_meter with a shortened tick divider and timeout.
`timescale 1ns/1ps
module tb_pulse_width_meter;

    localparam int TD = 4;
    localparam int TO = 2000;

    logic       clk;
    logic       rst;
    logic       PWM_In;
    logic [7:0] PulWid;
    logic       PulWid_Valid;
    logic       Sig_Lost;

    int tests_run = 0;
    int tests_failed = 0;

    int         strobe_cnt = 0;
    int         dbl_cnt = 0;
    logic       vld_d = 1'b0;
    logic [7:0] last_w = '0;
    logic [7:0] prev_w = '0;
    logic       lost_at_strobe = 1'b1;

    pulse_width_meter #(
        .TICK_DIV(TD), .MIN_WIDTH(80), .MAX_WIDTH(220), .TIMEOUT(TO), .FAILSAFE(0)
    ) dut (
        .clk(clk), .rst(rst), .PWM_In(PWM_In),
        .PulWid(PulWid), .PulWid_Valid(PulWid_Valid), .Sig_Lost(Sig_Lost)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    always @(posedge clk) begin
        if (PulWid_Valid) begin
            strobe_cnt     <= strobe_cnt + 1;
            prev_w         <= last_w;
            last_w         <= PulWid;
            lost_at_strobe <= Sig_Lost;
        end
        if (PulWid_Valid && vld_d) dbl_cnt <= dbl_cnt + 1;
        vld_d <= PulWid_Valid;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input int lsb);
        PWM_In = 1'b1;
        wait_cyc(lsb * TD);
        PWM_In = 1'b0;
    endtask

    task automatic low(input int lsb);
        PWM_In = 1'b0;
        wait_cyc(lsb * TD);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        PWM_In = 1'b0;
        wait_cyc(3);
        tests_run++;
        if (PulWid !== 8'd0) begin tests_failed++; $display("FAIL reset_pulwid got %0d want 0", PulWid); end
        tests_run++;
        if (PulWid_Valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %b want 0", PulWid_Valid); end
        tests_run++;
        if (Sig_Lost !== 1'b1) begin tests_failed++; $display("FAIL reset_lost got %b want 1", Sig_Lost); end
        rst = 1'b0;
        wait_cyc(10);
    endtask

    task automatic test_first_pulse();
        int s0;
        s0 = strobe_cnt;
        tests_run++;
        if (Sig_Lost !== 1'b1) begin tests_failed++; $display("FAIL first_lost_before got %b want 1", Sig_Lost); end
        pulse(150);
        wait_cyc(10);
        tests_run++;
        if (strobe_cnt - s0 !== 1) begin tests_failed++; $display("FAIL first_strobes got %0d want 1", strobe_cnt - s0); end
        tests_run++;
        if (last_w !== 8'd150) begin tests_failed++; $display("FAIL first_width got %0d want 150", last_w); end
        tests_run++;
        if (lost_at_strobe !== 1'b0) begin tests_failed++; $display("FAIL first_lost_at_strobe got %b want 0", lost_at_strobe); end
        tests_run++;
        if (Sig_Lost !== 1'b0) begin tests_failed++; $display("FAIL first_lost_after got %b want 0", Sig_Lost); end
    endtask

    task automatic test_accept_range();
        int s0;
        s0 = strobe_cnt;
        low(200);
        pulse(100);
        low(200);
        pulse(200);
        wait_cyc(10);
        tests_run++;
        if (strobe_cnt - s0 !== 2) begin tests_failed++; $display("FAIL range_strobes got %0d want 2", strobe_cnt - s0); end
        tests_run++;
        if (prev_w !== 8'd100) begin tests_failed++; $display("FAIL range_first got %0d want 100", prev_w); end
        tests_run++;
        if (PulWid !== 8'd200) begin tests_failed++; $display("FAIL range_second got %0d want 200", PulWid); end
        tests_run++;
        if (Sig_Lost !== 1'b0) begin tests_failed++; $display("FAIL range_lost got %b want 0", Sig_Lost); end
    endtask

    task automatic test_reject();
        int s0;
        low(20);
        pulse(150);
        wait_cyc(10);
        s0 = strobe_cnt;
        low(50); pulse(50);
        low(50); pulse(250);
        low(50); pulse(300);
        low(50);
        PWM_In = 1'b1; wait_cyc(2); PWM_In = 1'b0;
        low(50); pulse(79);
        low(50); pulse(221);
        low(50);
        tests_run++;
        if (strobe_cnt - s0 !== 0) begin tests_failed++; $display("FAIL reject_strobes got %0d want 0", strobe_cnt - s0); end
        tests_run++;
        if (PulWid !== 8'd150) begin tests_failed++; $display("FAIL reject_hold got %0d want 150", PulWid); end
        tests_run++;
        if (Sig_Lost !== 1'b0) begin tests_failed++; $display("FAIL reject_lost got %b want 0", Sig_Lost); end
    endtask

    task automatic test_bounds();
        pulse(80);
        wait_cyc(10);
        tests_run++;
        if (PulWid !== 8'd80) begin tests_failed++; $display("FAIL bound_min got %0d want 80", PulWid); end
        low(50);
        pulse(220);
        wait_cyc(10);
        tests_run++;
        if (PulWid !== 8'd220) begin tests_failed++; $display("FAIL bound_max got %0d want 220", PulWid); end
        low(20);
    endtask

    task automatic test_timeout();
        int s0;
        pulse(120);
        wait_cyc(10);
        s0 = strobe_cnt;
        wait_cyc((TO - 20) * TD);
        tests_run++;
        if (Sig_Lost !== 1'b0) begin tests_failed++; $display("FAIL timeout_early got %b want 0", Sig_Lost); end
        wait_cyc(40 * TD);
        tests_run++;
        if (Sig_Lost !== 1'b1) begin tests_failed++; $display("FAIL timeout_lost got %b want 1", Sig_Lost); end
        tests_run++;
        if (PulWid !== 8'd0) begin tests_failed++; $display("FAIL timeout_failsafe got %0d want 0", PulWid); end
        tests_run++;
        if (strobe_cnt - s0 !== 0) begin tests_failed++; $display("FAIL timeout_strobe got %0d want 0", strobe_cnt - s0); end
        pulse(180);
        wait_cyc(10);
        tests_run++;
        if (PulWid !== 8'd180) begin tests_failed++; $display("FAIL recover_width got %0d want 180", PulWid); end
        tests_run++;
        if (Sig_Lost !== 1'b0 || lost_at_strobe !== 1'b0) begin
            tests_failed++; $display("FAIL recover_lost got %b/%b want 0/0", Sig_Lost, lost_at_strobe);
        end
    endtask

    task automatic test_high_at_reset();
        int s0;
        rst = 1'b1;
        PWM_In = 1'b1;
        wait_cyc(3);
        rst = 1'b0;
        s0 = strobe_cnt;
        wait_cyc(100 * TD);
        PWM_In = 1'b0;
        low(50);
        pulse(120);
        wait_cyc(10);
        tests_run++;
        if (strobe_cnt - s0 !== 1) begin tests_failed++; $display("FAIL high_rst_strobes got %0d want 1", strobe_cnt - s0); end
        tests_run++;
        if (last_w !== 8'd120) begin tests_failed++; $display("FAIL high_rst_width got %0d want 120", last_w); end
    endtask

    task automatic test_reset_mid_pulse();
        int s0;
        low(20);
        s0 = strobe_cnt;
        PWM_In = 1'b1;
        wait_cyc(75 * TD);
        rst = 1'b1;
        wait_cyc(3);
        tests_run++;
        if (PulWid !== 8'd0 || PulWid_Valid !== 1'b0 || Sig_Lost !== 1'b1) begin
            tests_failed++;
            $display("FAIL midrst_outputs got %0d/%b/%b want 0/0/1", PulWid, PulWid_Valid, Sig_Lost);
        end
        rst = 1'b0;
        wait_cyc(75 * TD);
        PWM_In = 1'b0;
        wait_cyc(20);
        tests_run++;
        if (strobe_cnt - s0 !== 0) begin tests_failed++; $display("FAIL midrst_strobe got %0d want 0", strobe_cnt - s0); end
        tests_run++;
        if (PulWid !== 8'd0 || Sig_Lost !== 1'b1) begin
            tests_failed++; $display("FAIL midrst_hold got %0d/%b want 0/1", PulWid, Sig_Lost);
        end
        low(20);
        pulse(150);
        wait_cyc(10);
        tests_run++;
        if (PulWid !== 8'd150 || Sig_Lost !== 1'b0) begin
            tests_failed++; $display("FAIL midrst_fresh got %0d/%b want 150/0", PulWid, Sig_Lost);
        end
    endtask

    task automatic test_back_to_back();
        tests_run++;
        if (dbl_cnt !== 0) begin tests_failed++; $display("FAIL double_strobe got %0d want 0", dbl_cnt); end
    endtask

    initial begin
        rst = 1'b1;
        PWM_In = 1'b0;
        test_reset();
        test_first_pulse();
        test_accept_range();
        test_reject();
        test_bounds();
        test_timeout();
        test_high_at_reset();
        test_reset_mid_pulse();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pulse_width_meter.md
PULSE_WIDTH_METER -- requirements
Module: pulse_width_meter

Interface
REQ-001 Parameter TICK_DIV, default 100, clk cycles per width LSB (10 us at 10 MHz clk).
REQ-002 Parameter MIN_WIDTH, default 80, smallest accepted width in LSBs (800 us).
REQ-003 Parameter MAX_WIDTH, default 220, largest accepted width in LSBs (2200 us).
REQ-004 Parameter TIMEOUT, default 5000, ticks without an accepted pulse before loss is declared (50 ms); range 1..65535.
REQ-005 Parameter FAILSAFE, default 0, width reported while signal is lost.
REQ-006 Port clk  input  1  single system clock; all logic on its rising edge.
REQ-007 Port rst  input  1  reset, asynchronous, active-high.
REQ-008 Port PWM_In  input  1  raw RC receiver channel pulse, asynchronous to clk.
REQ-009 Port PulWid  output  8  last accepted pulse width in LSBs; feeds the mode-switch PulWid_En/PulWid_Alter inputs.
REQ-010 Port PulWid_Valid  output  1  one-cycle strobe when PulWid is updated by a new accepted pulse.
REQ-011 Port Sig_Lost  output  1  high while no accepted pulse has arrived within TIMEOUT ticks.

Function
REQ-012 PWM_In SHALL pass through a 2-flop synchronizer; edge detection SHALL compare the synchronized value with its previous-cycle copy.
REQ-013 Rising/falling edge SHALL be detected 2 clk after the corresponding PWM_In transition (synchronizer latency).
REQ-014 Prescaler SHALL count 0..TICK_DIV-1, emit a one-cycle tick on wrap, and be cleared to 0 on every detected rising edge.
REQ-015 FSM states: IDLE, HIGH, LOW; reset state IDLE.
REQ-016 IDLE: wait for rising edge -> HIGH; an input already high at reset exit SHALL NOT count as a rising edge.
REQ-017 HIGH: width counter cleared on entry, +1 per tick, saturating at 255.
REQ-018 HIGH, falling edge: if MIN_WIDTH <= width <= MAX_WIDTH, PulWid <= width and PulWid_Valid = 1 next cycle; otherwise pulse rejected, PulWid unchanged, no strobe; either way -> LOW.
REQ-019 HIGH with width saturated at 255: remain in HIGH; the eventual falling edge is rejected per REQ-018.
REQ-020 LOW: rising edge -> HIGH; glitches shorter than 1 tick yield width 0 and are rejected.
REQ-021 Gap counter (16 bit, saturating) SHALL increment per tick in every state and clear on each accepted pulse.
REQ-022 When gap counter reaches TIMEOUT, Sig_Lost = 1 and PulWid = FAILSAFE on the following cycle; no PulWid_Valid strobe for this change.
REQ-023 Sig_Lost SHALL clear in the same cycle PulWid_Valid asserts for the next accepted pulse.
REQ-024 Accepted pulse and timeout in the same cycle: acceptance wins; Sig_Lost = 0, PulWid = measured width.
REQ-025 PulWid_Valid SHALL never be high for two consecutive cycles.

Reset
REQ-026 While rst = 1: state IDLE, synchronizer and edge history flops = 1, prescaler, width and gap counters = 0.
REQ-027 Outputs under reset: PulWid = FAILSAFE, PulWid_Valid = 0, Sig_Lost = 1.
REQ-028 Reset asserted mid-pulse SHALL discard the partial measurement; the first measurement after release starts at a fresh rising edge.

Verification (defaults, 10 MHz clk)
REQ-029 Reset release, then 1500 us high pulse -> one PulWid_Valid strobe, PulWid = 150, Sig_Lost 1 -> 0 on strobe cycle.
REQ-030 Pulses of 1000 us then 2000 us, 20 ms period -> PulWid 100 then 200, one strobe each, Sig_Lost stays 0.
REQ-031 Pulses of 500 us and 2500 us after a valid 150 -> no strobe, PulWid holds 150.
REQ-032 PWM_In held low 50 ms after last accepted pulse -> Sig_Lost = 1, PulWid = 0; next 1800 us pulse -> PulWid = 180, Sig_Lost = 0.
REQ-033 PWM_In high at reset release, falls, then 1200 us pulse -> only the 1200 us pulse reported (PulWid = 120).
REQ-034 rst pulsed mid-way through a 1500 us pulse -> outputs return to reset values, no strobe for that pulse.
